// File: rtl/lmsm_pkg.sv
// Shared state encoding and width constants for the LM/SM memory-stage sequencer.
package lmsm_pkg;

    localparam int MASK_W    = 8;
    localparam int REG_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit encoder over the LM/SM register mask; last flags a single remaining bit.
module lmsm_prio_enc
    import lmsm_pkg::*;
(
    input  logic [MASK_W-1:0]    mask,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 last
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (mask[i] && !found) begin
                idx   = REG_IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign last = (mask != '0) && ((mask & (mask - MASK_W'(1))) == '0);

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands one LM/SM request into one data-memory access per set mask bit.
// Optional abort input enabled by defining LMSM_ABORT_EN.
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef LMSM_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic                 is_store,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [MASK_W-1:0]    reg_mask,
    output logic [REG_IDX_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0]    rf_rd_data,
    output logic                 rf_wr_en,
    output logic [REG_IDX_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0]    rf_wr_data,
    output logic [ADDR_W-1:0]    mem_access_addr,
    output logic [DATA_W-1:0]    mem_write_data,
    output logic                 mem_write_en,
    output logic                 mem_read,
    input  logic [DATA_W-1:0]    mem_read_data,
    output logic                 busy,
    output logic                 done
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                store_q, store_d;
    logic [REG_IDX_W-1:0] idx;
    logic                last;

    lmsm_prio_enc u_prio_enc (
        .mask (mask_q),
        .idx  (idx),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        mask_d          = mask_q;
        store_d         = store_q;
        rf_rd_addr      = '0;
        rf_wr_en        = 1'b0;
        rf_wr_addr      = '0;
        rf_wr_data      = '0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    store_d = is_store;
                    addr_d  = base_addr;
                    mask_d  = reg_mask;
                    state_d = (reg_mask != '0) ? RUN : FINISH;
                end
            end
            RUN: begin
                busy            = 1'b1;
                mem_access_addr = addr_q;
                if (store_q) begin
                    rf_rd_addr     = idx;
                    mem_write_data = rf_rd_data;
                    mem_write_en   = 1'b1;
                end else begin
                    mem_read   = 1'b1;
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = idx;
                    rf_wr_data = mem_read_data;
                end
                mask_d = mask_q & ~(MASK_W'(1) << idx);
                addr_d = addr_q + ADDR_W'(1);
                if (last) begin
                    state_d = FINISH;
                end
`ifdef LMSM_ABORT_EN
                if (abort) begin
                    mem_write_en = 1'b0;
                    mem_read     = 1'b0;
                    rf_wr_en     = 1'b0;
                    mask_d       = '0;
                    state_d      = IDLE;
                end
`endif
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: directed table, corner sequences, random vs. reference model.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;
    logic        busy;
    logic        done;
`ifdef LMSM_ABORT_EN
    logic        abort;
`endif

    logic [15:0] mem [64];
    logic [15:0] rf  [8];

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        mem_we;
        logic        mem_rd;
        logic        rf_we;
        logic [2:0]  rf_wr_addr;
        logic [2:0]  rf_rd_addr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rf_wdata;
    } outv_t;

    typedef struct {
        bit          st;
        logic [15:0] base;
        logic [7:0]  mask;
        int          exp_n;
        string       name;
    } vec_t;

    assign rf_rd_data    = rf[rf_rd_addr];
    assign mem_read_data = mem[mem_access_addr[5:0]];

    always #5 clk = ~clk;

    lmsm_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef LMSM_ABORT_EN
        .abort           (abort),
`endif
        .start           (start),
        .is_store        (is_store),
        .base_addr       (base_addr),
        .reg_mask        (reg_mask),
        .rf_rd_addr      (rf_rd_addr),
        .rf_rd_data      (rf_rd_data),
        .rf_wr_en        (rf_wr_en),
        .rf_wr_addr      (rf_wr_addr),
        .rf_wr_data      (rf_wr_data),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data),
        .busy            (busy),
        .done            (done)
    );

    function automatic outv_t actual();
        outv_t o;
        o.busy       = busy;
        o.done       = done;
        o.mem_we     = mem_write_en;
        o.mem_rd     = mem_read;
        o.rf_we      = rf_wr_en;
        o.rf_wr_addr = rf_wr_addr;
        o.rf_rd_addr = rf_rd_addr;
        o.addr       = mem_access_addr;
        o.wdata      = mem_write_data;
        o.rf_wdata   = rf_wr_data;
        return o;
    endfunction

    // Reference: the k-th access (k = 0..N-1) touches the k-th set bit in
    // ascending order at base+k; done follows the last access.
    function automatic outv_t model(input bit st, input logic [15:0] base,
                                    input logic [7:0] mask, input int c);
        outv_t       o;
        int          idxs[$];
        int          k;
        logic [15:0] a;
        o = '0;
        for (int i = 0; i < 8; i++) if (mask[i]) idxs.push_back(i);
        if (c >= 1 && c <= idxs.size()) begin
            k      = c - 1;
            a      = base + 16'(k);
            o.busy = 1'b1;
            o.addr = a;
            if (st) begin
                o.mem_we     = 1'b1;
                o.rf_rd_addr = 3'(idxs[k]);
                o.wdata      = rf[idxs[k]];
            end else begin
                o.mem_rd     = 1'b1;
                o.rf_we      = 1'b1;
                o.rf_wr_addr = 3'(idxs[k]);
                o.rf_wdata   = mem[a[5:0]];
            end
        end else if (c == idxs.size() + 1) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic chk_out(input string name, input int c, input outv_t exp);
        outv_t act;
        act = actual();
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %h want %h", name, c, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    // Compare, then commit this cycle's writes into the bench memories.
    task automatic step(input string name, input int c, input outv_t exp);
        chk_out(name, c, exp);
        if (mem_write_en) mem[mem_access_addr[5:0]] = mem_write_data;
        if (rf_wr_en) rf[rf_wr_addr] = rf_wr_data;
    endtask

    task automatic run_seq(input bit st, input logic [15:0] base, input logic [7:0] mask,
                           input bit hold, input string name,
                           output int busy_cnt, output int done_cyc);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (mask[i]) n++;
        @(negedge clk);
        start = 1'b1; is_store = st; base_addr = base; reg_mask = mask;
        busy_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) busy_cnt++;
            if (done && done_cyc < 0) done_cyc = c;
            step(name, c, model(st, base, mask, c));
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) rf[i] = 16'(i + 16);
        for (int i = 0; i < 64; i++) mem[i] = 16'hdead;
        mem[1] = 16'd1; mem[2] = 16'd5; mem[3] = 16'd3;
    endtask

    vec_t vecs[4];
    int   bc, dc;
    bit   seen_done;

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
`ifdef LMSM_ABORT_EN
        abort = 1'b0;
`endif
        preload();
        @(negedge clk);
        chk_out("reset_state", 0, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_out("post_reset_idle", 0, '0);

        vecs[0] = '{1'b0, 16'd1,      8'b1000_0101, 3, "lm_basic"};
        vecs[1] = '{1'b1, 16'd8,      8'hFF,        8, "sm_full"};
        vecs[2] = '{1'b0, 16'd40,     8'h00,        0, "zero_mask"};
        vecs[3] = '{1'b1, 16'hFFFF,   8'b0000_0011, 2, "sm_wrap"};

        for (int v = 0; v < 4; v++) begin
            preload();
            run_seq(vecs[v].st, vecs[v].base, vecs[v].mask, 1'b0, vecs[v].name, bc, dc);
            chk_int({vecs[v].name, "_busy_cycles"}, bc, vecs[v].exp_n);
            chk_int({vecs[v].name, "_done_cycle"}, dc, vecs[v].exp_n + 1);
            if (v == 0) begin
                chk_int("lm_r0", int'(rf[0]), 1);
                chk_int("lm_r2", int'(rf[2]), 5);
                chk_int("lm_r7", int'(rf[7]), 3);
            end
            if (v == 1) begin
                for (int i = 0; i < 8; i++) chk_int("sm_mem", int'(mem[8 + i]), 16 + i);
            end
            if (v == 3) begin
                chk_int("wrap_mem_ffff", int'(mem[63]), 16);
                chk_int("wrap_mem_0000", int'(mem[0]), 17);
            end
        end

        // start held through RUN/FINISH: one sequence, re-accepted in cycle N+2
        preload();
        run_seq(1'b0, 16'd4, 8'b0011_0010, 1'b1, "hold_start", bc, dc);
        chk_int("hold_done_cycle", dc, 4);
        @(negedge clk);
        start = 1'b0;
        chk_int("hold_second_busy", int'(busy), 1);
        chk_int("hold_second_addr", int'(mem_access_addr), 4);
        seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            @(negedge clk);
            seen_done = done;
        end
        chk_int("hold_second_done", int'(seen_done), 1);

        // reset asserted in cycle 2 of a 4-access LM
        preload();
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; base_addr = 16'd20; reg_mask = 8'b0101_1010;
        @(negedge clk);
        start = 1'b0;
        step("rst_mid", 1, model(1'b0, 16'd20, 8'b0101_1010, 1));
        @(negedge clk);
        step("rst_mid", 2, model(1'b0, 16'd20, 8'b0101_1010, 2));
        #1 rst = 1'b1;
        #1 chk_out("rst_immediate", 2, '0);
        #1 rst = 1'b0;
        for (int c = 3; c < 9; c++) begin
            @(negedge clk);
            chk_out("rst_quiet", c, '0);
        end

`ifdef LMSM_ABORT_EN
        // abort in cycle 2 of the same LM: access suppressed, back to IDLE
        preload();
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; base_addr = 16'd20; reg_mask = 8'b0101_1010;
        @(negedge clk);
        start = 1'b0;
        step("abort_seq", 1, model(1'b0, 16'd20, 8'b0101_1010, 1));
        @(negedge clk);
        abort = 1'b1;
        #1 begin
            outv_t e;
            e = model(1'b0, 16'd20, 8'b0101_1010, 2);
            e.mem_rd = 1'b0;
            e.rf_we  = 1'b0;
            step("abort_cycle", 2, e);
        end
        for (int c = 3; c < 9; c++) begin
            @(negedge clk);
            abort = 1'b0;
            chk_out("abort_idle", c, '0);
        end
`endif

        // randomized requests against the reference model
        for (int r = 0; r < 40; r++) begin
            logic [15:0] b;
            logic [7:0]  m;
            bit          st;
            int          n;
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
            st = 1'($urandom_range(0, 1));
            b  = (r % 5 == 0) ? 16'hFFFF - 16'($urandom_range(0, 6)) : 16'($urandom);
            m  = 8'($urandom_range(0, 255));
            n  = 0;
            for (int i = 0; i < 8; i++) if (m[i]) n++;
            run_seq(st, b, m, 1'b0, "random", bc, dc);
            chk_int("random_busy_cycles", bc, n);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
